wb_trace_monitor: RTL and testbench
===================================

WB_TRACE_MONITOR -- requirements
Module: wb_trace_monitor

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO entry count (power of two, >= 4).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port pc  input  32  PC of the instruction performing the write.
REQ-005 SHALL have port grf_we  input  1  register-file write enable.
REQ-006 SHALL have port grf_addr  input  5  register-file write address.
REQ-007 SHALL have port grf_wdata  input  32  register-file write data.
REQ-008 SHALL have port dm_we  input  1  data-memory write enable.
REQ-009 SHALL have port dm_addr  input  32  data-memory byte address.
REQ-010 SHALL have port dm_wdata  input  32  data-memory write data.
REQ-011 SHALL have port trace_ready  input  1  consumer accepts the head entry.
REQ-012 SHALL have port clr_ovf  input  1  synchronous clear of overflow and drop_count.
REQ-013 SHALL have port trace_valid  output  1  head entry available.
REQ-014 SHALL have port trace_kind  output  1  0 = GRF write, 1 = DM write.
REQ-015 SHALL have port trace_pc  output  32  PC of the head entry.
REQ-016 SHALL have port trace_addr  output  32  zero-extended grf_addr or dm_addr.
REQ-017 SHALL have port trace_data  output  32  write data of the head entry.
REQ-018 SHALL have port overflow  output  1  sticky flag, set when any event is dropped.
REQ-019 SHALL have port drop_count  output  16  count of dropped events.

Function
REQ-020 SHALL sample write events at each posedge; a GRF event is grf_we=1 with grf_addr!=0; a DM event is dm_we=1.
REQ-021 SHALL NOT log GRF writes to address 0.
REQ-022 SHALL store each event as {kind, pc, addr, data} in a circular FIFO of DEPTH entries with read and write pointers that wrap from DEPTH-1 to 0.
REQ-023 SHALL raise trace_valid in the cycle after the capturing edge (latency 1) when the FIFO was empty.
REQ-024 SHALL pop the head entry on a posedge where trace_valid=1 and trace_ready=1; trace_ready with trace_valid=0 has no effect.
REQ-025 SHALL hold trace_kind/pc/addr/data stable while trace_valid=1 and trace_ready=0.
REQ-026 SHALL drive trace_kind/pc/addr/data to 0 when the FIFO is empty.
REQ-027 SHALL, when GRF and DM events occur in the same cycle, enqueue GRF first and DM second.
REQ-028 SHALL compute free space as DEPTH - count + pop, so a same-cycle pop makes room for a push when full.
REQ-029 SHALL, when free space is insufficient, drop the DM event first and then the GRF event.
REQ-030 SHALL add 1 or 2 dropped events to drop_count, saturating at 16'hFFFF, and set overflow.
REQ-031 SHALL, on clr_ovf=1, clear overflow and drop_count to 0; drops in the same cycle take priority: overflow=1 and drop_count = number dropped that cycle.
REQ-032 SHALL keep count in the range 0..DEPTH; push and pop in the same cycle on a non-full FIFO leaves count unchanged.

Reset
REQ-033 SHALL, on reset=0 and regardless of clk, clear pointers, count, overflow, and drop_count, set trace_valid=0, and set trace data outputs to 0.
REQ-034 SHALL discard all buffered entries on reset mid-stream and capture no events while reset=0.
REQ-035 SHALL capture the first event at the first posedge after reset returns to 1.

Verification
REQ-036 Bench SHALL cover single GRF write: pc=32'h3000, grf_addr=5, grf_wdata=32'h1234, ready=1 -> next cycle valid=1, kind=0, addr=5, data=32'h1234; valid=0 after the pop.
REQ-037 Bench SHALL cover $0 filter: grf_we=1, grf_addr=0 -> trace_valid stays 0 and drop_count stays 0.
REQ-038 Bench SHALL cover simultaneous events into an empty FIFO: GRF and DM in one cycle, dm_addr=32'h10 -> two entries appear in the order kind=0 then kind=1.
REQ-039 Bench SHALL cover overflow: ready=0 with 10 DM writes and DEPTH=8 -> overflow=1, drop_count=2, the 8 oldest entries drain in order; then clr_ovf -> overflow=0 and drop_count=0.
REQ-040 Bench SHALL cover full with pop: FIFO holds 8 entries, ready=1, and 1 new event in the same cycle -> no drop, count remains 8.
REQ-041 Bench SHALL cover reset mid-stream: 3 entries queued, reset pulsed low between edges -> immediately valid=0, outputs 0, overflow=0, and no stale entries after release.

Source files
------------

// File: rtl/wb_trace_monitor.sv
// wb_trace_monitor: captures register-file and data-memory write events
// from a processor core into a circular FIFO and presents them one at a
// time on a valid/ready trace port. Events that find no room are counted
// in a saturating drop counter and flagged by a sticky overflow bit.
module wb_trace_monitor #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic        grf_we,
    input  logic [4:0]  grf_addr,
    input  logic [31:0] grf_wdata,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic        trace_ready,
    input  logic        clr_ovf,
    output logic        trace_valid,
    output logic        trace_kind,
    output logic [31:0] trace_pc,
    output logic [31:0] trace_addr,
    output logic [31:0] trace_data,
    output logic        overflow,
    output logic [15:0] drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 97;  // {kind, pc, addr, data}
    localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [15:0]   r_drop_count;

    logic          w_grf_ev;
    logic          w_dm_ev;
    logic          w_pop;
    logic [CW-1:0] w_free;
    logic          w_grf_acc;
    logic          w_dm_acc;
    logic [1:0]    w_n_acc;
    logic [1:0]    w_n_drop;
    logic [AW-1:0] w_dm_wptr;
    logic [EW-1:0] w_grf_entry;
    logic [EW-1:0] w_dm_entry;
    logic [EW-1:0] w_head;

    // Add up to two dropped events to the counter, pinning at all-ones.
    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Event decode and admission: a pop this cycle frees a slot for a push,
    // GRF is admitted before DM so DM is the first to be dropped.
    always_comb begin
        w_grf_ev    = grf_we && (grf_addr != 5'd0);
        w_dm_ev     = dm_we;
        w_pop       = (r_count != '0) && trace_ready;
        w_free      = LP_DEPTH - r_count + {{AW{1'b0}}, w_pop};
        w_grf_acc   = w_grf_ev && (w_free != '0);
        w_dm_acc    = w_dm_ev && (w_grf_acc ? (w_free >= CW'(2)) : (w_free != '0));
        w_n_acc     = {1'b0, w_grf_acc} + {1'b0, w_dm_acc};
        w_n_drop    = ({1'b0, w_grf_ev} + {1'b0, w_dm_ev}) - w_n_acc;
        w_dm_wptr   = r_wptr + {{(AW-1){1'b0}}, w_grf_acc};
        w_grf_entry = {1'b0, pc, 27'd0, grf_addr, grf_wdata};
        w_dm_entry  = {1'b1, pc, dm_addr, dm_wdata};
    end

    // Entry storage; GRF lands at the write pointer, DM right behind it.
    always_ff @(posedge clk) begin
        if (w_grf_acc) r_mem[r_wptr]    <= w_grf_entry;
        if (w_dm_acc)  r_mem[w_dm_wptr] <= w_dm_entry;
    end

    // Pointers, occupancy and overflow bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= 16'd0;
        end else begin
            r_wptr  <= r_wptr + AW'(w_n_acc);
            r_rptr  <= r_rptr + {{(AW-1){1'b0}}, w_pop};
            r_count <= r_count + CW'(w_n_acc) - CW'(w_pop);
            if (w_n_drop != 2'd0) begin
                // A drop in the same cycle as a clear wins over the clear.
                r_overflow   <= 1'b1;
                r_drop_count <= clr_ovf ? {14'd0, w_n_drop} : sat_add(r_drop_count, w_n_drop);
            end else if (clr_ovf) begin
                r_overflow   <= 1'b0;
                r_drop_count <= 16'd0;
            end
        end
    end

    // Head presentation: fields are forced to zero whenever the FIFO is empty.
    always_comb begin
        w_head      = r_mem[r_rptr];
        trace_valid = (r_count != '0);
        {trace_kind, trace_pc, trace_addr, trace_data} = trace_valid ? w_head : '0;
        overflow    = r_overflow;
        drop_count  = r_drop_count;
    end

endmodule

// File: tb/tb_wb_trace_monitor.sv
// Scoreboard bench for wb_trace_monitor: the driver feeds a queue-based
// reference FIFO, a monitor on the falling edge compares the DUT head,
// overflow and drop counter against it and pops on accepted handshakes.
module tb_wb_trace_monitor;

    localparam int DEPTH = 8;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc = '0;
    logic        grf_we = 1'b0;
    logic [4:0]  grf_addr = '0;
    logic [31:0] grf_wdata = '0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        trace_ready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        trace_valid;
    logic        trace_kind;
    logic [31:0] trace_pc;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic        overflow;
    logic [15:0] drop_count;

    ent_t        sbq[$];
    logic        m_ovf = 1'b0;
    int unsigned m_dc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          started = 1'b0;

    wb_trace_monitor #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pc(pc),
        .grf_we(grf_we), .grf_addr(grf_addr), .grf_wdata(grf_wdata),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .trace_ready(trace_ready), .clr_ovf(clr_ovf),
        .trace_valid(trace_valid), .trace_kind(trace_kind),
        .trace_pc(trace_pc), .trace_addr(trace_addr), .trace_data(trace_data),
        .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour for one clock edge: the monitor has already
    // removed the entry being popped, so queue room is the free space.
    task automatic model_update();
        int drops;
        ent_t e;
        drops = 0;
        if (reset !== 1'b1) return;
        if (grf_we && grf_addr != 5'd0) begin
            e = '{kind: 1'b0, pc: pc, addr: {27'd0, grf_addr}, data: grf_wdata};
            if (sbq.size() < DEPTH) sbq.push_back(e); else drops++;
        end
        if (dm_we) begin
            e = '{kind: 1'b1, pc: pc, addr: dm_addr, data: dm_wdata};
            if (sbq.size() < DEPTH) sbq.push_back(e); else drops++;
        end
        if (drops > 0) begin
            m_ovf = 1'b1;
            if (clr_ovf) m_dc = drops;
            else m_dc = (m_dc + drops > 32'hFFFF) ? 32'hFFFF : m_dc + drops;
        end else if (clr_ovf) begin
            m_ovf = 1'b0;
            m_dc  = 0;
        end
    endtask

    // Monitor: compare presented head and status, pop on handshake.
    always @(negedge clk) begin
        if (started && reset === 1'b1) begin
            chk("mon_valid", 64'(trace_valid), 64'(sbq.size() != 0));
            if (sbq.size() != 0) begin
                chk("mon_kind", 64'(trace_kind), 64'(sbq[0].kind));
                chk("mon_pc",   64'(trace_pc),   64'(sbq[0].pc));
                chk("mon_addr", 64'(trace_addr), 64'(sbq[0].addr));
                chk("mon_data", 64'(trace_data), 64'(sbq[0].data));
                if (trace_ready) void'(sbq.pop_front());
            end else begin
                chk("mon_empty_fields", {trace_pc, trace_addr} ^ 64'(trace_data) ^ 64'(trace_kind), 64'd0);
            end
            chk("mon_overflow", 64'(overflow), 64'(m_ovf));
            chk("mon_drop_count", 64'(drop_count), 64'(m_dc));
        end
    end

    // Drive one cycle; called and returning 2 time units after a posedge.
    task automatic step(input bit gw, input logic [4:0] ga, input logic [31:0] gd,
                        input bit dw, input logic [31:0] da, input logic [31:0] dd,
                        input logic [31:0] p, input bit rdy, input bit clr);
        grf_we = gw; grf_addr = ga; grf_wdata = gd;
        dm_we = dw; dm_addr = da; dm_wdata = dd;
        pc = p; trace_ready = rdy; clr_ovf = clr;
        @(negedge clk);
        #1;
        model_update();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, rdy, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sbq.size() != 0; i++) idle(1'b1);
        idle(1'b1);
        chk("drain_done", 64'(sbq.size()), 64'd0);
        chk("drain_valid", 64'(trace_valid), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1;
        chk("rst_valid", 64'(trace_valid), 64'd0);
        chk("rst_fields", {trace_pc, trace_addr} | 64'(trace_data) | 64'(trace_kind), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_dc", 64'(drop_count), 64'd0);
        @(posedge clk); @(posedge clk); #2;
        reset = 1'b1;
        started = 1'b1;

        // Single GRF write, popped on the following edge.
        step(1'b1, 5'd5, 32'h1234, 1'b0, 32'd0, 32'd0, 32'h3000, 1'b1, 1'b0);
        chk("grf_valid", 64'(trace_valid), 64'd1);
        chk("grf_kind", 64'(trace_kind), 64'd0);
        chk("grf_addr", 64'(trace_addr), 64'd5);
        chk("grf_data", 64'(trace_data), 64'h1234);
        chk("grf_pc", 64'(trace_pc), 64'h3000);
        idle(1'b1);
        chk("grf_popped", 64'(trace_valid), 64'd0);

        // Writes to $0 are ignored.
        step(1'b1, 5'd0, 32'hDEAD, 1'b0, 32'd0, 32'd0, 32'h3004, 1'b1, 1'b0);
        chk("zero_valid", 64'(trace_valid), 64'd0);
        chk("zero_dc", 64'(drop_count), 64'd0);

        // Simultaneous GRF and DM: GRF first.
        step(1'b1, 5'd7, 32'h77, 1'b1, 32'h10, 32'h99, 32'h3008, 1'b0, 1'b0);
        chk("dual_first_kind", 64'(trace_kind), 64'd0);
        chk("dual_first_addr", 64'(trace_addr), 64'd7);
        idle(1'b1);
        chk("dual_second_kind", 64'(trace_kind), 64'd1);
        chk("dual_second_addr", 64'(trace_addr), 64'h10);
        idle(1'b1);
        chk("dual_empty", 64'(trace_valid), 64'd0);

        // Ten DM writes with a stalled consumer: two dropped.
        for (int i = 0; i < 10; i++)
            step(1'b0, 5'd0, 32'd0, 1'b1, 32'h100 + 32'(i * 4), 32'hA000 + 32'(i), 32'h4000 + 32'(i * 4), 1'b0, 1'b0);
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_dc", 64'(drop_count), 64'd2);
        chk("ovf_head", 64'(trace_data), 64'hA000);
        drain();
        step(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("clr_ovf", 64'(overflow), 64'd0);
        chk("clr_dc", 64'(drop_count), 64'd0);

        // Full FIFO with a pop and a push in the same cycle.
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 5'd0, 32'd0, 1'b1, 32'h200 + 32'(i), $urandom, 32'h5000, 1'b0, 1'b0);
        step(1'b1, 5'd9, 32'hBEEF, 1'b0, 32'd0, 32'd0, 32'h5100, 1'b1, 1'b0);
        chk("full_pop_ovf", 64'(overflow), 64'd0);
        chk("full_pop_dc", 64'(drop_count), 64'd0);
        n = 0;
        while (trace_valid && n < 20) begin
            idle(1'b1);
            n++;
        end
        chk("full_pop_count", 64'(n), 64'(DEPTH));

        // Randomised traffic: a congested phase, then a draining phase.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 1) == 1, $urandom, $urandom, $urandom,
                 (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 19) == 0);
        end
        drain();

        // Reset in the middle of a stream.
        for (int i = 1; i <= 3; i++)
            step(1'b1, 5'(i), 32'(i), 1'b0, 32'd0, 32'd0, 32'h6000, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        sbq.delete();
        m_ovf = 1'b0;
        m_dc = 0;
        chk("mid_rst_valid", 64'(trace_valid), 64'd0);
        chk("mid_rst_fields", {trace_pc, trace_addr} | 64'(trace_data) | 64'(trace_kind), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        chk("mid_rst_dc", 64'(drop_count), 64'd0);
        step(1'b1, 5'd4, 32'h44, 1'b1, 32'h8, 32'h88, 32'h6100, 1'b0, 1'b0);
        chk("in_rst_capture", 64'(trace_valid), 64'd0);
        #1;
        reset = 1'b1;
        #1;
        step(1'b1, 5'd9, 32'hABCD, 1'b0, 32'd0, 32'd0, 32'h7000, 1'b0, 1'b0);
        chk("post_rst_valid", 64'(trace_valid), 64'd1);
        chk("post_rst_addr", 64'(trace_addr), 64'd9);
        chk("post_rst_data", 64'(trace_data), 64'hABCD);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
